// File: rtl/color_reg_pkg.sv
// Shared types and defaults for the PPU colour register controller.
package color_reg_pkg;

  localparam int NUM_REGS_DEF = 4;
  localparam int DATA_W_DEF   = 32;
  localparam int CNT_W        = 16;

  typedef enum logic [1:0] {
    IDLE,
    DIRTY,
    COMMIT
  } state_t;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/color_reg_bank.sv
// Colour register bank: one write port and one registered read port.
// Out-of-range writes are dropped; out-of-range reads return zero.
module color_reg_bank
  import color_reg_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Read samples the pre-write contents, so a same-cycle write is not visible.
  always_comb begin
    mem_d     = mem_q;
    rd_data_d = rd_data_q;
    if (wr_en && addr_in_range(32'(wr_addr), NUM_REGS)) begin
      mem_d[wr_addr] = wr_data;
    end
    if (rd_en) begin
      rd_data_d = addr_in_range(32'(rd_addr), NUM_REGS) ? mem_q[rd_addr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/color_reg_ctrl.sv
// Shadow/active colour register controller with a vblank-triggered,
// tear-free shadow-to-active commit and host/commit shadow read arbitration.
module color_reg_ctrl
  import color_reg_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic              host_rd_valid,
  output logic              host_rd_ready,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic              host_rd_data_valid,
  output logic [DATA_W-1:0] host_rd_data,
  input  logic [ADDR_W-1:0] ppu_rd_addr,
  output logic [DATA_W-1:0] ppu_rd_data,
  input  logic              vblank,
  output logic              dirty,
  output logic              commit_busy,
  output logic [15:0]       commit_count
);

  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                vblank_q;
  logic                rd_valid_q;
  logic                copy_pend_q, copy_pend_d;
  logic [ADDR_W-1:0]   copy_addr_q, copy_addr_d;

  logic                wr_accept, rd_accept, wr_take, vblank_rise;
  logic                shadow_rd_en;
  logic [ADDR_W-1:0]   shadow_rd_addr;
  logic [DATA_W-1:0]   shadow_rd_data;

  assign host_wr_ready = (state_q != COMMIT);
  assign host_rd_ready = (state_q != COMMIT);
  assign wr_accept     = host_wr_valid & host_wr_ready;
  assign rd_accept     = host_rd_valid & host_rd_ready;
  assign wr_take       = wr_accept & addr_in_range(32'(host_wr_addr), NUM_REGS);
  assign vblank_rise   = vblank & ~vblank_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    copy_pend_d = (state_q == COMMIT);
    copy_addr_d = idx_q;
    case (state_q)
      IDLE: begin
        if (wr_take) begin
          state_d = vblank_rise ? COMMIT : DIRTY;
        end
      end
      DIRTY: begin
        if (vblank_rise) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (idx_q == IDX_LAST) begin
          state_d = IDLE;
          idx_d   = '0;
          count_d = count_q + CNT_W'(1);
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The commit sequencer owns the shadow read port while in COMMIT.
  always_comb begin
    shadow_rd_en   = rd_accept;
    shadow_rd_addr = host_rd_addr;
    if (state_q == COMMIT) begin
      shadow_rd_en   = 1'b1;
      shadow_rd_addr = idx_q;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      count_q     <= '0;
      vblank_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      copy_pend_q <= 1'b0;
      copy_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      vblank_q    <= vblank;
      rd_valid_q  <= rd_accept;
      copy_pend_q <= copy_pend_d;
      copy_addr_q <= copy_addr_d;
    end
  end

  color_reg_bank #(
    .NUM_REGS(NUM_REGS),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W)
  ) u_shadow (
    .clk    (ACLK),
    .srst   (ARESET),
    .wr_en  (wr_accept),
    .wr_addr(host_wr_addr),
    .wr_data(host_wr_data),
    .rd_en  (shadow_rd_en),
    .rd_addr(shadow_rd_addr),
    .rd_data(shadow_rd_data)
  );

  // Each shadow entry read during COMMIT lands in the active bank one cycle later.
  color_reg_bank #(
    .NUM_REGS(NUM_REGS),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W)
  ) u_active (
    .clk    (ACLK),
    .srst   (ARESET),
    .wr_en  (copy_pend_q),
    .wr_addr(copy_addr_q),
    .wr_data(shadow_rd_data),
    .rd_en  (1'b1),
    .rd_addr(ppu_rd_addr),
    .rd_data(ppu_rd_data)
  );

  assign host_rd_data_valid = rd_valid_q;
  assign host_rd_data       = shadow_rd_data;
  assign dirty              = (state_q == DIRTY);
  assign commit_busy        = (state_q == COMMIT);
  assign commit_count       = count_q;

endmodule
